// File: rtl/dawncarol_key_pkg.sv
// Shared definitions for the dawncarol_key push-button path: event code layout and default timing.
// The optional auto-repeat feature is enabled with DAWNCAROL_KEY_REPEAT_EN.
package dawncarol_key_pkg;

    localparam int EVT_PRESS_BIT  = 7;
    localparam int EVT_REPEAT_BIT = 6;
    localparam int EVT_IDX_LSB    = 0;
    localparam int EVT_IDX_W      = 4;

    typedef struct packed {
        logic                 press;
        logic                 rpt;
        logic [1:0]           rsvd;
        logic [EVT_IDX_W-1:0] idx;
    } evt_code_t;

    localparam logic [31:0] DEF_DEBOUNCE_CNT     = 32'd999_999;
    localparam logic [31:0] DEF_REPEAT_DELAY_CNT = 32'd24_999_999;
    localparam logic [31:0] DEF_REPEAT_RATE_CNT  = 32'd4_999_999;

    function automatic evt_code_t make_evt(input logic press, input logic rpt,
                                           input logic [EVT_IDX_W-1:0] idx);
        evt_code_t c;
        c.press = press;
        c.rpt   = rpt;
        c.rsvd  = 2'b00;
        c.idx   = idx;
        return c;
    endfunction

endpackage

// File: rtl/dawncarol_key_debounce.sv
// One key: 2-flop synchroniser, polarity normalisation, debounce counter, level and pulses.
// With DAWNCAROL_KEY_REPEAT_EN defined, also a hold-time auto-repeat counter.
module dawncarol_key_debounce
    import dawncarol_key_pkg::*;
#(
    parameter logic [31:0] DEBOUNCE_CNT     = DEF_DEBOUNCE_CNT,
    parameter logic        KEY_ACTIVE_LOW   = 1'b1,
    parameter logic [31:0] REPEAT_DELAY_CNT = DEF_REPEAT_DELAY_CNT,
    parameter logic [31:0] REPEAT_RATE_CNT  = DEF_REPEAT_RATE_CNT
) (
    input  logic clk,
    input  logic reset,
    input  logic key_raw,
    output logic key_state,
    output logic key_press,
    output logic key_release,
    output logic key_repeat
);

    logic        sync1_q, sync1_d;
    logic        sync2_q, sync2_d;
    logic        state_q, state_d;
    logic        press_q, press_d;
    logic        release_q, release_d;
    logic [31:0] cnt_q, cnt_d;
    logic        key_sync;

    always_comb begin
        sync1_d   = key_raw;
        sync2_d   = sync1_q;
        key_sync  = KEY_ACTIVE_LOW ? ~sync2_q : sync2_q;
        state_d   = state_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        cnt_d     = 32'd0;
        if (key_sync != state_q) begin
            if (cnt_q == DEBOUNCE_CNT) begin
                state_d   = key_sync;
                press_d   = key_sync;
                release_d = ~key_sync;
            end else begin
                cnt_d = cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q   <= KEY_ACTIVE_LOW;
            sync2_q   <= KEY_ACTIVE_LOW;
            state_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            cnt_q     <= 32'd0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            state_q   <= state_d;
            press_q   <= press_d;
            release_q <= release_d;
            cnt_q     <= cnt_d;
        end
    end

    assign key_state   = state_q;
    assign key_press   = press_q;
    assign key_release = release_q;

`ifdef DAWNCAROL_KEY_REPEAT_EN
    logic [31:0] rpt_cnt_q, rpt_cnt_d;
    logic        rpt_phase_q, rpt_phase_d;
    logic        rpt_q, rpt_d;
    logic [31:0] rpt_term;

    // Phase 0 waits out the initial hold delay, phase 1 paces the repeats.
    always_comb begin
        rpt_cnt_d   = 32'd0;
        rpt_phase_d = 1'b0;
        rpt_d       = 1'b0;
        rpt_term    = rpt_phase_q ? REPEAT_RATE_CNT : REPEAT_DELAY_CNT;
        if (state_q && state_d) begin
            if (rpt_cnt_q == rpt_term) begin
                rpt_d       = 1'b1;
                rpt_phase_d = 1'b1;
            end else begin
                rpt_cnt_d   = rpt_cnt_q + 32'd1;
                rpt_phase_d = rpt_phase_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rpt_cnt_q   <= 32'd0;
            rpt_phase_q <= 1'b0;
            rpt_q       <= 1'b0;
        end else begin
            rpt_cnt_q   <= rpt_cnt_d;
            rpt_phase_q <= rpt_phase_d;
            rpt_q       <= rpt_d;
        end
    end

    assign key_repeat = rpt_q;
`else
    logic unused_repeat_cfg;
    assign unused_repeat_cfg = ^{REPEAT_DELAY_CNT, REPEAT_RATE_CNT};
    assign key_repeat        = 1'b0;
`endif

endmodule

// File: rtl/dawncarol_key.sv
// Debounced key bank with a single-entry valid/ready event register and sticky overflow flag.
// Define DAWNCAROL_KEY_REPEAT_EN to add hold-to-repeat events.
module dawncarol_key
    import dawncarol_key_pkg::*;
#(
    parameter int          NUM_KEYS         = 4,
    parameter logic [31:0] DEBOUNCE_CNT     = DEF_DEBOUNCE_CNT,
    parameter logic        KEY_ACTIVE_LOW   = 1'b1,
    parameter logic [31:0] REPEAT_DELAY_CNT = DEF_REPEAT_DELAY_CNT,
    parameter logic [31:0] REPEAT_RATE_CNT  = DEF_REPEAT_RATE_CNT
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_KEYS-1:0] key_in,
    output logic [NUM_KEYS-1:0] key_state,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic                evt_valid,
    input  logic                evt_ready,
    output logic [7:0]          evt_code,
    output logic                evt_overflow
);

    logic [NUM_KEYS-1:0] key_rpt;

    for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
        dawncarol_key_debounce #(
            .DEBOUNCE_CNT     (DEBOUNCE_CNT),
            .KEY_ACTIVE_LOW   (KEY_ACTIVE_LOW),
            .REPEAT_DELAY_CNT (REPEAT_DELAY_CNT),
            .REPEAT_RATE_CNT  (REPEAT_RATE_CNT)
        ) u_debounce (
            .clk         (clk),
            .reset       (reset),
            .key_raw     (key_in[g]),
            .key_state   (key_state[g]),
            .key_press   (key_press[g]),
            .key_release (key_release[g]),
            .key_repeat  (key_rpt[g])
        );
    end

    logic                 evt_valid_q, evt_valid_d;
    evt_code_t            evt_code_q, evt_code_d;
    logic                 evt_overflow_q, evt_overflow_d;
    logic                 cand_found, cand_press, cand_rpt;
    logic [EVT_IDX_W-1:0] cand_idx;
    logic [5:0]           n_cand;
    logic                 can_capture;

    // Downward scans let the lowest index win; edge pulses override repeats.
    always_comb begin
        cand_found = 1'b0;
        cand_press = 1'b0;
        cand_rpt   = 1'b0;
        cand_idx   = '0;
        n_cand     = 6'd0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            n_cand = n_cand + {5'd0, key_press[i] | key_release[i]} + {5'd0, key_rpt[i]};
        end
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (key_rpt[i]) begin
                cand_found = 1'b1;
                cand_press = 1'b1;
                cand_rpt   = 1'b1;
                cand_idx   = EVT_IDX_W'(i);
            end
        end
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (key_press[i] || key_release[i]) begin
                cand_found = 1'b1;
                cand_press = key_press[i];
                cand_rpt   = 1'b0;
                cand_idx   = EVT_IDX_W'(i);
            end
        end
    end

    always_comb begin
        can_capture    = !evt_valid_q || evt_ready;
        evt_valid_d    = evt_valid_q && !evt_ready;
        evt_code_d     = evt_code_q;
        evt_overflow_d = evt_overflow_q;
        if (cand_found && can_capture) begin
            evt_valid_d = 1'b1;
`ifdef DAWNCAROL_KEY_REPEAT_EN
            evt_code_d  = make_evt(cand_press, cand_rpt, cand_idx);
`else
            evt_code_d  = make_evt(cand_press, 1'b0, cand_idx);
`endif
        end
        if ((cand_found && !can_capture) || (n_cand > 6'd1)) begin
            evt_overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            evt_valid_q    <= 1'b0;
            evt_code_q     <= '0;
            evt_overflow_q <= 1'b0;
        end else begin
            evt_valid_q    <= evt_valid_d;
            evt_code_q     <= evt_code_d;
            evt_overflow_q <= evt_overflow_d;
        end
    end

    assign evt_valid    = evt_valid_q;
    assign evt_code     = evt_code_q;
    assign evt_overflow = evt_overflow_q;

endmodule
